serializer_10b: RTL

SERIALIZER_10B -- requirements
Module: serializer_10b

---
 rtl/serializer_10b_pkg.sv | 24 ++
 rtl/sym_fifo2.sv | 45 ++++
 rtl/serializer_10b.sv | 89 ++++++++
 3 files changed

// File: rtl/serializer_10b_pkg.sv
// Shared constants, state encoding and bit-select helper for the 10b serializer.
package serializer_10b_pkg;

  localparam int SYM_W      = 10;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] CNT_LAST = 4'd9;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Serial bit for position idx of a symbol, honoring transmit order.
  function automatic logic sym_bit(sym_t s, logic [CNT_W-1:0] idx, bit lsb_first);
    logic [CNT_W-1:0] pos;
    pos = lsb_first ? idx : (CNT_LAST - idx);
    return s[pos];
  endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry symbol FIFO with registered ready; entry 0 is always the head.
module sym_fifo2
  import serializer_10b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  sym_t push_data,
  input  logic pop,
  output sym_t head,
  output logic empty,
  output logic ready
);

  localparam logic [1:0] DEPTH_Q = 2'(FIFO_DEPTH);

  sym_t       mem [FIFO_DEPTH];
  logic [1:0] occ, occ_nxt, wr_pos;
  logic       do_push, do_pop;

  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign empty   = (occ == 2'd0);
  assign head    = mem[0];

  always_comb begin
    occ_nxt = occ + {1'b0, do_push} - {1'b0, do_pop};
    wr_pos  = occ - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ   <= 2'd0;
      ready <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      occ   <= occ_nxt;
      ready <= (occ_nxt < DEPTH_Q);
      if (do_pop) mem[0] <= mem[1];
      // A write landing on slot 0 during a pop must override the shift.
      if (do_push) mem[wr_pos[0]] <= push_data;
    end
  end

endmodule

// File: rtl/serializer_10b.sv
// 10b symbol serializer: 2-deep input FIFO feeding a shifter, one bit per clk.
module serializer_10b
  import serializer_10b_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             clr_underrun,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             underrun
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  sym_t             shreg, shreg_nxt;
  sym_t             head;
  logic             empty, push, pop, load, set_ur;
  logic             ser_out_nxt, frame_nxt, underrun_nxt;

  assign push = sym_valid & sym_ready;

  sym_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (sym_in),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .ready     (sym_ready)
  );

  // A new symbol starts from IDLE or directly after the last bit, never mid-symbol.
  assign load = ~empty & ((state == ST_IDLE) | (cnt == CNT_LAST));
  assign busy = (state == ST_SHIFT);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    ser_out_nxt = 1'b0;
    frame_nxt   = 1'b0;
    pop         = 1'b0;
    set_ur      = 1'b0;
    if (load) begin
      pop         = 1'b1;
      state_nxt   = ST_SHIFT;
      shreg_nxt   = head;
      cnt_nxt     = '0;
      ser_out_nxt = sym_bit(head, '0, LSB_FIRST);
      frame_nxt   = 1'b1;
    end else if (state == ST_SHIFT) begin
      if (cnt == CNT_LAST) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        set_ur    = 1'b1;
      end else begin
        cnt_nxt     = cnt + 4'd1;
        ser_out_nxt = sym_bit(shreg, cnt + 4'd1, LSB_FIRST);
      end
    end
    underrun_nxt = set_ur | (underrun & ~clr_underrun);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      ser_out   <= ser_out_nxt;
      ser_frame <= frame_nxt;
      underrun  <= underrun_nxt;
    end
  end

endmodule
